// File: rtl/cyq_seq_detector.sv
// -----------------------------------------------------------------------------
// cyq_seq_detector
//
// Serial pattern detector fed by a clock-aligned bit stream (the Q output of an
// upstream D flip-flop). Valid bits are shifted into a PLEN-bit window. Each
// time the window equals PATTERN, a one-cycle hit pulse is produced and a
// saturating match counter increments.
//
// Parameters:
//   PLEN    - pattern length in bits (2..8)
//   PATTERN - pattern to match; MSB = oldest bit, LSB = newest bit
//   CNT_W   - match counter width (2..16)
//
// Ports:
//   clk   - clock; all state updates on the rising edge
//   rd    - asynchronous active-low reset
//   en    - din is valid this cycle
//   din   - serial data bit
//   ovl   - 1: overlapping matches allowed, 0: window restarts after a match
//   clr   - synchronous clear of window, count, sat and hit (beats en)
//   hit   - registered single-cycle match pulse
//   count - saturating number of matches since reset/clr
//   sat   - sticky flag, set once count reaches all-ones
//   fill  - number of valid bits currently held in the window (0..PLEN)
//
// The FSM state (FILLING / ARMED) is implied by fill: ARMED when fill == PLEN.
// -----------------------------------------------------------------------------
module cyq_seq_detector #(
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1101,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rd,
    input  logic             en,
    input  logic             din,
    input  logic             ovl,
    input  logic             clr,
    output logic             hit,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic [3:0]       fill
);

    typedef enum logic {
        FILLING,
        ARMED
    } state_e;

    localparam logic [3:0]       PLEN_F  = 4'(PLEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PLEN-1:0]  win_q,   win_d;
    logic [3:0]       fill_q,  fill_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q,   sat_d;
    logic             hit_q,   hit_d;

    state_e           state;
    logic [PLEN-1:0]  nwin;
    logic [3:0]       nfill;
    logic             match;

    assign state = (fill_q == PLEN_F) ? ARMED : FILLING;

    // Candidate window/fill if the current bit is accepted.
    assign nwin  = {win_q[PLEN-2:0], din};
    assign nfill = (state == ARMED) ? PLEN_F : fill_q + 4'd1;
    // A match needs a full window, so bits never accepted cannot contribute.
    assign match = (nfill == PLEN_F) && (nwin == PATTERN);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge rd) begin
        if (!rd) begin
            win_q   <= '0;
            fill_q  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            hit_q   <= hit_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        win_d   = win_q;
        fill_d  = fill_q;
        count_d = count_q;
        sat_d   = sat_q;
        hit_d   = 1'b0;

        if (clr) begin
            // The bit on din this cycle is discarded.
            win_d   = '0;
            fill_d  = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (en) begin
            if (match) begin
                hit_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                // Covers both "about to reach all-ones" and "already there".
                if (count_q >= CNT_MAX - 1'b1) begin
                    sat_d = 1'b1;
                end
                if (ovl) begin
                    win_d  = nwin;
                    fill_d = PLEN_F;
                end else begin
                    win_d  = '0;
                    fill_d = '0;
                end
            end else begin
                win_d  = nwin;
                fill_d = nfill;
            end
        end
    end

    assign hit   = hit_q;
    assign count = count_q;
    assign sat   = sat_q;
    assign fill  = fill_q;

endmodule

// File: tb/tb_cyq_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_cyq_seq_detector
//
// Drives two detector instances with the same stream: one with default
// parameters (8-bit counter) and one with a 2-bit counter so saturation is
// reached quickly. A queue-based model of the accepted bit history predicts
// every output and is compared on each falling edge; directed sequences with
// literal expectations pin the model down.
// -----------------------------------------------------------------------------
module tb_cyq_seq_detector;

    localparam int       PLEN = 4;
    localparam bit [3:0] PAT  = 4'b1101;
    localparam int       MAX8 = 255;
    localparam int       MAX2 = 3;

    logic       clk;
    logic       rd;
    logic       en;
    logic       din;
    logic       ovl;
    logic       clr;

    logic       hit;
    logic [7:0] count;
    logic       sat;
    logic [3:0] fill;

    logic       hit2;
    logic [1:0] count2;
    logic       sat2;
    logic [3:0] fill2;

    int n_checks;
    int n_err;
    int hits;
    int hits_base;
    bit chk_on;

    // Model state: accepted bits since the last restart, oldest first.
    bit hist[$];
    bit exp_hit;
    int exp_cnt;
    int exp_cnt2;

    cyq_seq_detector dut (
        .clk   (clk),
        .rd    (rd),
        .en    (en),
        .din   (din),
        .ovl   (ovl),
        .clr   (clr),
        .hit   (hit),
        .count (count),
        .sat   (sat),
        .fill  (fill)
    );

    cyq_seq_detector #(
        .CNT_W (2)
    ) dut2 (
        .clk   (clk),
        .rd    (rd),
        .en    (en),
        .din   (din),
        .ovl   (ovl),
        .clr   (clr),
        .hit   (hit2),
        .count (count2),
        .sat   (sat2),
        .fill  (fill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: match = last PLEN accepted bits equal the pattern.
    // ---------------------------------------------------------------------
    always @(posedge clk or negedge rd) begin
        if (!rd || clr) begin
            hist.delete();
            exp_hit  = 1'b0;
            exp_cnt  = 0;
            exp_cnt2 = 0;
        end else if (!en) begin
            exp_hit = 1'b0;
        end else begin
            bit m;
            hist.push_back(din);
            if (hist.size() > PLEN) void'(hist.pop_front());
            m = (hist.size() == PLEN);
            for (int k = 0; k < PLEN; k++) begin
                if (m && hist[k] != PAT[PLEN-1-k]) m = 1'b0;
            end
            exp_hit = m;
            if (m) begin
                exp_cnt  = (exp_cnt  < MAX8) ? exp_cnt  + 1 : MAX8;
                exp_cnt2 = (exp_cnt2 < MAX2) ? exp_cnt2 + 1 : MAX2;
                if (!ovl) hist.delete();
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("hit",    int'(hit),    int'(exp_hit));
            check("fill",   int'(fill),   hist.size());
            check("count",  int'(count),  exp_cnt);
            check("sat",    int'(sat),    int'(exp_cnt == MAX8));
            check("hit2",   int'(hit2),   int'(exp_hit));
            check("fill2",  int'(fill2),  hist.size());
            check("count2", int'(count2), exp_cnt2);
            check("sat2",   int'(sat2),   int'(exp_cnt2 == MAX2));
        end
    end

    always @(negedge clk) begin
        if (hit) hits <= hits + 1;
    end

    // Present one set of inputs for the next rising edge.
    task automatic send(input bit e, input bit d, input bit o, input bit c);
        @(negedge clk);
        en  = e;
        din = d;
        ovl = o;
        clr = c;
    endtask

    // Let the last edge's outputs become visible, inputs idle.
    task automatic settle();
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b0;
        #1;
    endtask

    task automatic restart();
        send(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        hits_base = hits;
    endtask

    task automatic send_seq(input bit [6:0] bits, input int n, input bit o);
        for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i], o, 1'b0);
    endtask

    initial begin
        bit [6:0] stream;
        n_checks  = 0;
        n_err     = 0;
        hits      = 0;
        hits_base = 0;
        chk_on    = 1'b0;
        rd  = 1'b0;
        en  = 1'b0;
        din = 1'b0;
        ovl = 1'b0;
        clr = 1'b0;
        stream = 7'b1101101;

        #12;
        check("rst_hit",   int'(hit),   0);
        check("rst_count", int'(count), 0);
        check("rst_sat",   int'(sat),   0);
        check("rst_fill",  int'(fill),  0);
        rd = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;

        // Overlapping matches.
        restart();
        send_seq(stream, 7, 1'b1);
        settle();
        check("ovl_hits",  hits - hits_base, 2);
        check("ovl_count", int'(count), 2);
        check("ovl_fill",  int'(fill),  4);

        // Non-overlapping.
        restart();
        send_seq(stream, 7, 1'b0);
        settle();
        check("novl_hits",  hits - hits_base, 1);
        check("novl_count", int'(count), 1);
        check("novl_fill",  int'(fill),  3);

        // Valid gaps with random din while en=0.
        restart();
        stream = 7'b0001101;
        for (int i = 3; i >= 0; i--) begin
            send(1'b0, 1'($urandom), 1'b1, 1'b0);
            send(1'b0, 1'($urandom), 1'b1, 1'b0);
            send(1'b1, stream[i], 1'b1, 1'b0);
        end
        settle();
        check("gap_hit_now", int'(hit), 1);
        check("gap_hits",    hits - hits_base, 1);
        check("gap_count",   int'(count), 1);

        // Saturation on the 2-bit counter.
        restart();
        for (int g = 0; g < 5; g++) begin
            send_seq(stream, 4, 1'b1);
            settle();
            check("sat_hit",    int'(hit2),   1);
            check("sat_count2", int'(count2), (g < 3) ? g + 1 : 3);
            check("sat_sat2",   int'(sat2),   (g >= 2) ? 1 : 0);
        end
        check("sat_hits", hits - hits_base, 5);

        // Asynchronous reset mid-window.
        restart();
        send_seq(7'b0000110, 3, 1'b1);
        settle();
        @(posedge clk);
        #2 rd = 1'b0;
        #1;
        check("arst_fill",  int'(fill),  0);
        check("arst_count", int'(count), 0);
        rd = 1'b1;
        send(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("arst_hits",   hits - hits_base, 0);
        check("arst_count2", int'(count), 0);
        check("arst_fill2",  int'(fill),  1);

        // clr on the completing edge.
        restart();
        send_seq(7'b0000110, 3, 1'b1);
        send(1'b1, 1'b1, 1'b1, 1'b1);
        settle();
        check("clr_hits",  hits - hits_base, 0);
        check("clr_count", int'(count), 0);
        check("clr_fill",  int'(fill),  0);

        // Randomized traffic with occasional clr and async reset.
        for (int i = 0; i < 3000; i++) begin
            send($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
            if (i % 700 == 350) begin
                #2 rd = 1'b0;
                #1 rd = 1'b1;
            end
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
